tlb_refill_walker: RTL and testbench

TLB_REFILL_WALKER -- requirements
Module: tlb_refill_walker

---
 rtl/tlb_refill_walker.sv | 164 ++++++++++++++++
 tb/tb_tlb_refill_walker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill_walker.sv
// Two-level page-table walker that refills one TLB entry per miss (4 KiB pages and superpage splinters).
// Optional: define TLB_WALK_AD_FAULT_EN to fault on leaves with A=0 instead of filling them.
module tlb_refill_walker (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_i,
  input  logic [19:0] vpn_i,
  input  logic [21:0] satp_ppn,
  output logic        mem_req,
  output logic [33:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        tlb_we,
  output logic [4:0]  tlb_write_addr,
  output logic [51:0] tlb_write_data,
  output logic        busy,
  output logic        done,
  output logic        page_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WALK1 = 3'd1,
    S_WALK2 = 3'd2,
    S_FILL  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] vpn_q, vpn_d;
  logic [21:0] pte1_ppn_q, pte1_ppn_d;
  logic [21:0] fill_ppn_q, fill_ppn_d;
  logic [9:0]  fill_flags_q, fill_flags_d;
  logic [4:0]  victim_q, victim_d;

  logic pte_v, pte_r, pte_w, pte_x;
  logic pte_invalid, pte_leaf, pte_misaligned, pte_ad_ok;

  always_comb begin
    pte_v          = mem_rdata[0];
    pte_r          = mem_rdata[1];
    pte_w          = mem_rdata[2];
    pte_x          = mem_rdata[3];
    pte_invalid    = !pte_v || (!pte_r && pte_w);
    pte_leaf       = !pte_invalid && (pte_r || pte_x);
    pte_misaligned = (mem_rdata[19:10] != 10'd0);
`ifdef TLB_WALK_AD_FAULT_EN
    pte_ad_ok      = mem_rdata[6];
`else
    pte_ad_ok      = 1'b1;
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vpn_q        <= '0;
      pte1_ppn_q   <= '0;
      fill_ppn_q   <= '0;
      fill_flags_q <= '0;
      victim_q     <= '0;
    end else begin
      state_q      <= state_d;
      vpn_q        <= vpn_d;
      pte1_ppn_q   <= pte1_ppn_d;
      fill_ppn_q   <= fill_ppn_d;
      fill_flags_q <= fill_flags_d;
      victim_q     <= victim_d;
    end
  end

  // Next-state logic; a PTE is consumed only in the WALK states, where mem_req is high
  always_comb begin
    state_d      = state_q;
    vpn_d        = vpn_q;
    pte1_ppn_d   = pte1_ppn_q;
    fill_ppn_d   = fill_ppn_q;
    fill_flags_d = fill_flags_q;
    victim_d     = victim_q;
    case (state_q)
      S_IDLE: begin
        if (miss_i) begin
          vpn_d   = vpn_i;
          state_d = S_WALK1;
        end
      end
      S_WALK1: begin
        if (mem_ack) begin
          if (pte_invalid) begin
            state_d = S_FAULT;
          end else if (pte_leaf) begin
            if (pte_misaligned || !pte_ad_ok) begin
              state_d = S_FAULT;
            end else begin
              // Superpage is splintered into the 4 KiB page the miss touched
              fill_ppn_d   = {mem_rdata[31:20], vpn_q[9:0]};
              fill_flags_d = mem_rdata[9:0];
              state_d      = S_FILL;
            end
          end else begin
            pte1_ppn_d = mem_rdata[31:10];
            state_d    = S_WALK2;
          end
        end
      end
      S_WALK2: begin
        if (mem_ack) begin
          if (pte_leaf && pte_ad_ok) begin
            fill_ppn_d   = mem_rdata[31:10];
            fill_flags_d = mem_rdata[9:0];
            state_d      = S_FILL;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_FILL: begin
        victim_d = victim_q + 5'd1;
        state_d  = S_IDLE;
      end
      S_FAULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req        = 1'b0;
    mem_addr       = '0;
    tlb_we         = 1'b0;
    tlb_write_addr = '0;
    tlb_write_data = '0;
    done           = 1'b0;
    page_fault     = 1'b0;
    busy           = (state_q != S_IDLE);
    case (state_q)
      S_WALK1: begin
        mem_req  = 1'b1;
        mem_addr = {satp_ppn, vpn_q[19:10], 2'b00};
      end
      S_WALK2: begin
        mem_req  = 1'b1;
        mem_addr = {pte1_ppn_q, vpn_q[9:0], 2'b00};
      end
      S_FILL: begin
        tlb_we         = 1'b1;
        done           = 1'b1;
        tlb_write_addr = victim_q;
        tlb_write_data = {vpn_q, fill_ppn_q, fill_flags_q};
      end
      S_FAULT: begin
        page_fault = 1'b1;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed and randomized walks checked against a page-table reference model.
module tb_tlb_refill_walker;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_i;
  logic [19:0] vpn_i;
  logic [21:0] satp_ppn;
  logic        mem_req;
  logic [33:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        tlb_we;
  logic [4:0]  tlb_write_addr;
  logic [51:0] tlb_write_data;
  logic        busy;
  logic        done;
  logic        page_fault;

  int n_cmp = 0;
  int n_err = 0;
  logic [4:0] victim_m = 5'd0;

  always #5 clk = ~clk;

  tlb_refill_walker dut (
    .clk            (clk),
    .rst            (rst),
    .miss_i         (miss_i),
    .vpn_i          (vpn_i),
    .satp_ppn       (satp_ppn),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .tlb_we         (tlb_we),
    .tlb_write_addr (tlb_write_addr),
    .tlb_write_data (tlb_write_data),
    .busy           (busy),
    .done           (done),
    .page_fault     (page_fault)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 = invalid, 1 = leaf, 2 = pointer
  function automatic int pte_kind(input logic [31:0] p);
    if (!p[0] || (!p[1] && p[2])) return 0;
    if (p[1] || p[3]) return 1;
    return 2;
  endfunction

  function automatic bit ad_pass(input logic [31:0] p);
`ifdef TLB_WALK_AD_FAULT_EN
    return p[6];
`else
    return 1'b1;
`endif
  endfunction

  // Serves one PTE read with d wait cycles; checks the request is held stable meanwhile.
  task automatic mem_access(input logic [63:0] a, input logic [31:0] p, input int d,
                            input bit noise, input string tag);
    for (int k = 0; k <= d; k++) begin
      chk({tag, "_req"}, {63'd0, mem_req}, 64'd1);
      chk({tag, "_addr"}, {30'd0, mem_addr}, a);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
      chk({tag, "_we"}, {63'd0, tlb_we}, 64'd0);
      mem_ack   = (k == d);
      mem_rdata = (k == d) ? p : $urandom;
      miss_i    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      vpn_i     = 20'($urandom);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    miss_i  = 1'b0;
  endtask

  task automatic walk(input logic [19:0] v, input logic [31:0] p1, input logic [31:0] p2,
                      input int d1, input int d2, input bit noise);
    logic [63:0] a1, a2, data, vv, ppn_sp;
    bit fill;
    int k1;
    vv   = {44'd0, v};
    data = 64'd0;
    fill = 1'b0;
    @(negedge clk);
    miss_i = 1'b1;
    vpn_i  = v;
    @(negedge clk);
    miss_i = 1'b0;
    a1 = ({42'd0, satp_ppn} * 64'd4096) + (vv / 64'd1024) * 64'd4;
    mem_access(a1, p1, d1, noise, "l1");
    k1 = pte_kind(p1);
    if (k1 == 1) begin
      if (((p1 / 32'd1024) % 32'd1024) == 32'd0 && ad_pass(p1)) begin
        fill   = 1'b1;
        ppn_sp = ({32'd0, p1} / 64'h100000) * 64'd1024 + (vv % 64'd1024);
        data   = vv * 64'h1_0000_0000 + ppn_sp * 64'd1024 + {32'd0, p1} % 64'd1024;
      end
    end else if (k1 == 2) begin
      a2 = ({32'd0, p1} / 64'd1024) * 64'd4096 + (vv % 64'd1024) * 64'd4;
      mem_access(a2, p2, d2, noise, "l2");
      if (pte_kind(p2) == 1 && ad_pass(p2)) begin
        fill = 1'b1;
        data = vv * 64'h1_0000_0000 + {32'd0, p2};
      end
    end
    chk("out_we", {63'd0, tlb_we}, {63'd0, fill});
    chk("out_done", {63'd0, done}, {63'd0, fill});
    chk("out_fault", {63'd0, page_fault}, {63'd0, !fill});
    chk("out_req", {63'd0, mem_req}, 64'd0);
    if (fill) begin
      chk("fill_addr", {59'd0, tlb_write_addr}, {59'd0, victim_m});
      chk("fill_data", {12'd0, tlb_write_data}, data);
      victim_m = victim_m + 5'd1;
    end
    @(negedge clk);
    chk("post_busy", {63'd0, busy}, 64'd0);
    chk("post_pulse", {61'd0, tlb_we, done, page_fault}, 64'd0);
  endtask

  initial begin
    logic [31:0] lp, pp;
    rst       = 1'b1;
    miss_i    = 1'b0;
    vpn_i     = 20'd0;
    satp_ppn  = 22'h00080;
    mem_ack   = 1'b0;
    mem_rdata = 32'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_outs", {57'd0, mem_req, tlb_we, done, page_fault, busy}, 64'd0);
    chk("rst_addr", {30'd0, mem_addr}, 64'd0);
    chk("rst_wdata", {12'd0, tlb_write_data}, 64'd0);
    chk("rst_waddr", {59'd0, tlb_write_addr}, 64'd0);
    rst = 1'b0;

    // Two-level, superpage, faults
    walk(20'h12345, 32'h00040001, 32'h200000CF, 0, 0, 0);
    walk(20'h12345, 32'h100000CB, 32'h0, 0, 0, 0);
    walk(20'h12345, 32'h0000040F, 32'h0, 0, 0, 0);
    walk(20'h12345, 32'h00000000, 32'h0, 0, 0, 0);
    walk(20'h12345, 32'h00040001, 32'h00000005, 0, 0, 0);
    walk(20'h12345, 32'h00040001, 32'h2000008F, 0, 0, 0);
    walk(20'h12345, 32'h00040001, 32'h200000CF, 3, 3, 1);

    // Ack with no request outstanding
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h200000CF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle_ack_busy", {63'd0, busy}, 64'd0);
    chk("idle_ack_we", {63'd0, tlb_we}, 64'd0);

    // Successful refills walk the victim counter through its wrap
    for (int i = 0; i < 33; i++) begin
      satp_ppn = 22'($urandom);
      pp = ($urandom & 32'hFFFF_FFF1) | 32'h1;
      lp = $urandom | 32'h0000_0043;
      walk(20'($urandom), pp, lp, 0, 0, 0);
    end

    // Mixed random walks
    for (int i = 0; i < 60; i++) begin
      satp_ppn = 22'($urandom);
      case ($urandom_range(0, 3))
        0: pp = ($urandom & 32'hFFFF_FFF1) | 32'h1;
        1: pp = ($urandom & 32'hFFF0_03FF) | 32'h3;
        2: pp = $urandom;
        default: pp = ($urandom & 32'hFFFF_FFF1) | 32'h1;
      endcase
      lp = ($urandom_range(0, 2) != 0) ? ($urandom | 32'h3) : $urandom;
      walk(20'($urandom), pp, lp, $urandom_range(0, 3), $urandom_range(0, 3), 1);
    end

    // Reset while WALK2 waits for its ack
    satp_ppn = 22'h00080;
    @(negedge clk);
    miss_i = 1'b1;
    vpn_i  = 20'h12345;
    @(negedge clk);
    miss_i    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h00040001;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("w2_req", {63'd0, mem_req}, 64'd1);
    chk("w2_addr", {30'd0, mem_addr}, 64'h100D14);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    victim_m = 5'd0;
    chk("abort_req", {63'd0, mem_req}, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h200000CF;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_we", {63'd0, tlb_we}, 64'd0);
    chk("late_ack_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("late_ack_we2", {63'd0, tlb_we}, 64'd0);
    walk(20'h12345, 32'h00040001, 32'h200000CF, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
